instr_encoder: RTL

- Reverse of the control decoder: converts symbolic instruction descriptors (mnemonic index plus fields) into 32-bit MIPS instruction words.
- Writes the words sequentially into instruction memory, acting as the program loader for the single-cycle model's testbenches and boot path.
- Descriptors enter through a valid/ready FIFO; encoded words leave through a write port with an acknowledge handshake.

---
 rtl/instr_encoder.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/instr_encoder.sv
// Instruction encoder / program loader.
// Turns symbolic instruction descriptors into 32-bit MIPS words and writes them
// sequentially into instruction memory through an acknowledged write port.
module instr_encoder #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_op,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_shamt,
  input  logic [25:0]       in_imm,
  input  logic              in_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  input  logic              imem_ack,
  output logic              busy,
  output logic              done,
  output logic              err_illegal,
  output logic              err_ovf,
  output logic [ADDR_W-3:0] word_count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0] FullCnt = (PW+1)'(DEPTH);

  typedef struct packed {
    logic [4:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [25:0] imm;
    logic        last;
  } desc_t;

  typedef enum logic [1:0] {StIdle, StRun, StWrite, StDone} state_t;

  state_t          state;
  desc_t           mem [DEPTH];
  desc_t           head;
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [PW:0]     count;
  logic            fifo_empty, fifo_full, push, pop;
  logic            last_q;
  logic [ADDR_W-1:0] addr_next;

  // Encoder intermediates
  logic [5:0]  opc, funct;
  logic        legal, is_i, is_j, is_shift, is_jr, is_lui;
  logic [4:0]  rs_f, rt_f, rd_f, sh_f;
  logic [31:0] enc_word;

  // Low address bits are always treated as zero.
  logic unused_base;
  assign unused_base = ^base_addr[1:0];

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == FullCnt);
  assign in_ready   = !fifo_full;
  assign push       = in_valid && !fifo_full;
  // Only StRun pops, so a pending write in StWrite blocks the FIFO.
  assign pop        = (state == StRun) && !fifo_empty;
  assign head       = mem[rd_ptr];
  assign busy       = (state != StIdle);
  assign addr_next  = imem_addr + ADDR_W'(4);

  // FIFO storage; no reset needed since count gates every read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= desc_t'{in_op, in_rs, in_rt, in_rd, in_shamt, in_imm, in_last};
  end

  // FIFO pointers and occupancy; reset flushes the queue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      count <= count + (PW+1)'(1);
      else if (pop && !push) count <= count - (PW+1)'(1);
    end
  end

  // Mnemonic lookup: opcode, funct and instruction format.
  always_comb begin
    opc   = 6'h00;
    funct = 6'h00;
    legal = 1'b1;
    is_i  = 1'b0;
    is_j  = 1'b0;
    case (head.op)
      5'd0:  funct = 6'h21;
      5'd1:  funct = 6'h20;
      5'd2:  funct = 6'h23;
      5'd3:  funct = 6'h22;
      5'd4:  funct = 6'h2A;
      5'd5:  funct = 6'h00;
      5'd6:  funct = 6'h02;
      5'd7:  funct = 6'h03;
      5'd8:  funct = 6'h24;
      5'd9:  funct = 6'h08;
      5'd10: begin opc = 6'h0D; is_i = 1'b1; end
      5'd11: begin opc = 6'h2B; is_i = 1'b1; end
      5'd12: begin opc = 6'h23; is_i = 1'b1; end
      5'd13: begin opc = 6'h04; is_i = 1'b1; end
      5'd14: begin opc = 6'h05; is_i = 1'b1; end
      5'd15: begin opc = 6'h0F; is_i = 1'b1; end
      5'd16: begin opc = 6'h0A; is_i = 1'b1; end
      5'd17: begin opc = 6'h02; is_j = 1'b1; end
      5'd18: begin opc = 6'h03; is_j = 1'b1; end
      default: legal = 1'b0;
    endcase
  end

  // Field forcing and word assembly.
  always_comb begin
    is_shift = (head.op == 5'd5) || (head.op == 5'd6) || (head.op == 5'd7);
    is_jr    = (head.op == 5'd9);
    is_lui   = (head.op == 5'd15);
    rs_f     = (is_shift || is_lui) ? 5'd0 : head.rs;
    rt_f     = is_jr ? 5'd0 : head.rt;
    rd_f     = is_jr ? 5'd0 : head.rd;
    sh_f     = is_shift ? head.shamt : 5'd0;
    if (is_j)      enc_word = {opc, head.imm};
    else if (is_i) enc_word = {opc, rs_f, rt_f, head.imm[15:0]};
    else           enc_word = {opc, rs_f, rt_f, rd_f, sh_f, funct};
  end

  // Control FSM with registered write-port and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= StIdle;
      imem_we     <= 1'b0;
      imem_addr   <= '0;
      imem_wdata  <= '0;
      done        <= 1'b0;
      err_illegal <= 1'b0;
      err_ovf     <= 1'b0;
      word_count  <= '0;
      last_q      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        StIdle: begin
          if (start) begin
            state       <= StRun;
            imem_addr   <= {base_addr[ADDR_W-1:2], 2'b00};
            word_count  <= '0;
            err_illegal <= 1'b0;
            err_ovf     <= 1'b0;
          end
        end
        StRun: begin
          if (!fifo_empty) begin
            if (!legal) begin
              err_illegal <= 1'b1;
              if (head.last) begin
                state <= StDone;
                done  <= 1'b1;
              end
            end else begin
              imem_wdata <= enc_word;
              imem_we    <= 1'b1;
              last_q     <= head.last;
              state      <= StWrite;
            end
          end
        end
        StWrite: begin
          if (imem_ack) begin
            imem_we    <= 1'b0;
            imem_addr  <= addr_next;
            word_count <= word_count + (ADDR_W-2)'(1);
            // Address wrap aborts the program; queued entries stay put.
            if (addr_next == '0) begin
              err_ovf <= 1'b1;
              state   <= StIdle;
            end else if (last_q) begin
              state <= StDone;
              done  <= 1'b1;
            end else begin
              state <= StRun;
            end
          end
        end
        StDone:  state <= StIdle;
        default: state <= StIdle;
      endcase
    end
  end

endmodule
